// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multi_cycle_ctrl_pkg
// Brief   : Opcode, state and ALU-op encodings plus the control-word type
//           shared by the multi-cycle MIPS control FSM.
// Revision: 1.0 - initial release
// ============================================================================
package multi_cycle_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_IMM_EXEC  = 4'd10;
    localparam logic [3:0] S_IMM_WB    = 4'd11;

    // Must match the downstream ALU control decoder.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl_out_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_out_decode
// Brief   : Combinational state + opcode to datapath control-word decoder.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_out_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      cw_o
);

    always_comb begin
        cw_o = '0;
        case (state_i)
            S_FETCH: begin
                cw_o.mem_read  = 1'b1;
                cw_o.alu_src_b = SRCB_FOUR;
                cw_o.ir_write  = mem_ready_i;
                cw_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                cw_o.alu_src_b = SRCB_IMMSH;
                cw_o.illegal   = ~is_legal_op(opcode_i);
            end
            S_MEM_ADDR: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                cw_o.mem_read = 1'b1;
                cw_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                cw_o.mem_write = 1'b1;
                cw_o.iord      = 1'b1;
            end
            S_EXECUTE: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_B;
                cw_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                cw_o.reg_write = 1'b1;
                cw_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_B;
                cw_o.alu_op    = ALU_SUB;
                cw_o.pc_source = PCSRC_ALUOUT;
                cw_o.pc_write  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
            end
            S_JUMP: begin
                cw_o.pc_source = PCSRC_JUMP;
                cw_o.pc_write  = 1'b1;
            end
            S_IMM_EXEC: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
                cw_o.alu_op    = (opcode_i == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            S_IMM_WB: begin
                cw_o.reg_write = 1'b1;
            end
            default: cw_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multi_cycle_ctrl
// Brief   : Main control FSM of the multi-cycle MIPS datapath with a
//           retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired,
    output logic [3:0]         state
);

    logic [3:0]         state_q, state_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
    logic               retire_w;
    ctrl_t              cw_w, cw_gated_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        retire_w = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_R:             state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IMM_EXEC;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_READ;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_FETCH;
            end
            S_MEM_READ: state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_d  = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire_w = mem_ready;
            end
            S_EXECUTE:  state_d = S_R_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_MEM_WB, S_R_WB, S_IMM_WB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_w = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
        retired_d = retired_q + COUNT_W'(retire_w);
    end

    ctrl_out_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .cw_o        (cw_w)
    );

    // Reset masks the control word so FETCH's read request is not issued while held.
    always_comb begin
        cw_gated_w = reset ? '0 : cw_w;
        pc_write   = cw_gated_w.pc_write;
        iord       = cw_gated_w.iord;
        mem_read   = cw_gated_w.mem_read;
        mem_write  = cw_gated_w.mem_write;
        ir_write   = cw_gated_w.ir_write;
        reg_dst    = cw_gated_w.reg_dst;
        mem_to_reg = cw_gated_w.mem_to_reg;
        reg_write  = cw_gated_w.reg_write;
        alu_src_a  = cw_gated_w.alu_src_a;
        alu_src_b  = cw_gated_w.alu_src_b;
        alu_op     = cw_gated_w.alu_op;
        pc_source  = cw_gated_w.pc_source;
        illegal    = cw_gated_w.illegal;
        retired    = retired_q;
        state      = state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_cycle_ctrl
// Brief   : Directed self-checking bench for the multi-cycle control FSM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] retired;
    logic [3:0]  state;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_ret = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal),
        .retired(retired), .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
        #3;
        n_total++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_total++;
        if (retired !== 32'd0) $display("FAIL reset_retired: got %0d want 0", retired); else n_pass++;
        n_total++;
        if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000", {mem_read, ir_write, pc_write, alu_src_b});
        else n_pass++;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_total++;
        if ({state, mem_read, ir_write, alu_src_b} !== {4'd0, 1'b1, 1'b1, 2'b01})
            $display("FAIL reset_release_fetch: got st=%0d rd=%b ir=%b b=%b want 0 1 1 01",
                     state, mem_read, ir_write, alu_src_b);
        else n_pass++;
    endtask

    task automatic test_lw_r();
        logic [3:0] exp_st [0:9];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        for (int i = 0; i < 10; i++) begin
            opcode    = (i < 5) ? OP_LW : OP_R;
            mem_ready = 1'b1;
            #1;
            n_total++;
            if (state !== exp_st[i]) $display("FAIL lw_r_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            else n_pass++;
            n_total++;
            if (reg_write !== (exp_st[i] == 4'd4 || exp_st[i] == 4'd7))
                $display("FAIL lw_r_reg_write[%0d]: got %b", i, reg_write);
            else n_pass++;
            if (exp_st[i] == 4'd4) begin
                n_total++;
                if (mem_to_reg !== 1'b1) $display("FAIL lw_wb_mem_to_reg: got %b want 1", mem_to_reg); else n_pass++;
            end
            if (exp_st[i] == 4'd7) begin
                n_total++;
                if (reg_dst !== 1'b1) $display("FAIL r_wb_reg_dst: got %b want 1", reg_dst); else n_pass++;
            end
            if (i < 9) tick();
        end
        exp_ret = exp_ret + 2;
        n_total++;
        if (retired !== exp_ret) $display("FAIL lw_r_retired: got %0d want %0d", retired, exp_ret); else n_pass++;
    endtask

    task automatic test_branch();
        logic [5:0] ops [0:3];
        logic       zs  [0:3];
        logic       pws [0:3];
        ops = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        zs  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pws = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k]; zero = zs[k]; mem_ready = 1'b1;
            #1; tick();
            n_total++;
            if (state !== 4'd1) $display("FAIL br_decode[%0d]: got %0d want 1", k, state); else n_pass++;
            tick();
            n_total++;
            if ({state, pc_write, pc_source, alu_op} !== {4'd8, pws[k], 2'b01, 2'b01})
                $display("FAIL br_exec[%0d]: got st=%0d pw=%b src=%b op=%b want 8 %b 01 01",
                         k, state, pc_write, pc_source, alu_op, pws[k]);
            else n_pass++;
            tick();
            exp_ret = exp_ret + 1;
            n_total++;
            if ({state, retired} !== {4'd0, exp_ret})
                $display("FAIL br_done[%0d]: got st=%0d ret=%0d want 0 %0d", k, state, retired, exp_ret);
            else n_pass++;
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        opcode = OP_J; mem_ready = 1'b1;
        #1; tick(); tick();
        n_total++;
        if ({state, pc_write, pc_source} !== {4'd9, 1'b1, 2'b10})
            $display("FAIL jump: got st=%0d pw=%b src=%b want 9 1 10", state, pc_write, pc_source);
        else n_pass++;
        tick();
        exp_ret = exp_ret + 1;
        n_total++;
        if ({state, retired} !== {4'd0, exp_ret})
            $display("FAIL jump_done: got st=%0d ret=%0d want 0 %0d", state, retired, exp_ret);
        else n_pass++;
    endtask

    task automatic test_sw_wait();
        int cycles = 0;
        opcode = OP_SW; mem_ready = 1'b0;
        // Two fetch wait cycles, then ready is ignored in DECODE/MEM_ADDR.
        for (int w = 0; w < 2; w++) begin
            #1;
            n_total++;
            if ({state, mem_read, ir_write, pc_write} !== {4'd0, 1'b1, 1'b0, 1'b0})
                $display("FAIL fetch_wait[%0d]: got st=%0d rd=%b ir=%b pw=%b want 0 1 0 0",
                         w, state, mem_read, ir_write, pc_write);
            else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        tick(); cycles++;
        mem_ready = 1'b0;
        tick(); cycles++;
        tick(); cycles++;
        for (int w = 0; w < 4; w++) begin
            mem_ready = (w == 3);
            #1;
            n_total++;
            if ({state, mem_write, iord, mem_read} !== {4'd5, 1'b1, 1'b1, 1'b0})
                $display("FAIL sw_hold[%0d]: got st=%0d wr=%b iord=%b rd=%b want 5 1 1 0",
                         w, state, mem_write, iord, mem_read);
            else n_pass++;
            tick(); cycles++;
        end
        exp_ret = exp_ret + 1;
        n_total++;
        if ({state, retired, cycles} !== {4'd0, exp_ret, 32'd7})
            $display("FAIL sw_done: got st=%0d ret=%0d cyc=%0d want 0 %0d 7", state, retired, cycles, exp_ret);
        else n_pass++;
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        #1; tick();
        n_total++;
        if ({state, illegal, reg_write, mem_write} !== {4'd1, 1'b1, 1'b0, 1'b0})
            $display("FAIL illegal_decode: got st=%0d ill=%b rw=%b mw=%b want 1 1 0 0",
                     state, illegal, reg_write, mem_write);
        else n_pass++;
        mem_ready = 1'b0;
        tick();
        n_total++;
        if ({state, illegal, retired} !== {4'd0, 1'b0, exp_ret})
            $display("FAIL illegal_next: got st=%0d ill=%b ret=%0d want 0 0 %0d", state, illegal, retired, exp_ret);
        else n_pass++;
    endtask

    task automatic test_imm();
        logic [5:0] ops [0:1];
        logic [1:0] aops [0:1];
        ops  = '{OP_ANDI, OP_ADDI};
        aops = '{2'b11, 2'b00};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k]; mem_ready = 1'b1;
            #1; tick(); tick();
            n_total++;
            if ({state, alu_op, alu_src_b, alu_src_a} !== {4'd10, aops[k], 2'b10, 1'b1})
                $display("FAIL imm_exec[%0d]: got st=%0d op=%b b=%b a=%b want 10 %b 10 1",
                         k, state, alu_op, alu_src_b, alu_src_a, aops[k]);
            else n_pass++;
            tick();
            n_total++;
            if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd11, 1'b1, 1'b0, 1'b0})
                $display("FAIL imm_wb[%0d]: got st=%0d rw=%b rd=%b m2r=%b want 11 1 0 0",
                         k, state, reg_write, reg_dst, mem_to_reg);
            else n_pass++;
            tick();
            exp_ret = exp_ret + 1;
            n_total++;
            if ({state, retired} !== {4'd0, exp_ret})
                $display("FAIL imm_done[%0d]: got st=%0d ret=%0d want 0 %0d", k, state, retired, exp_ret);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        opcode = OP_LW; mem_ready = 1'b1;
        #1; tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        n_total++;
        if ({state, mem_read, iord} !== {4'd3, 1'b1, 1'b1})
            $display("FAIL mid_read: got st=%0d rd=%b iord=%b want 3 1 1", state, mem_read, iord);
        else n_pass++;
        mem_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({state, mem_read, iord, reg_write, retired} !== {4'd0, 1'b0, 1'b0, 1'b0, 32'd0})
            $display("FAIL mid_reset: got st=%0d rd=%b iord=%b rw=%b ret=%0d want 0 0 0 0 0",
                     state, mem_read, iord, reg_write, retired);
        else n_pass++;
        tick();
        n_total++;
        if ({state, reg_write} !== {4'd0, 1'b0})
            $display("FAIL mid_reset_hold: got st=%0d rw=%b want 0 0", state, reg_write);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if ({state, mem_read, iord} !== {4'd0, 1'b1, 1'b0})
            $display("FAIL mid_reset_release: got st=%0d rd=%b iord=%b want 0 1 0", state, mem_read, iord);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lw_r();
        test_branch();
        test_jump();
        test_sw_wait();
        test_illegal();
        test_imm();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
